// File: rtl/branch_target_predictor.sv
// Fetch-stage branch target buffer: direct-mapped, per-entry saturating
// direction counter, combinational lookup and resolution, EX-stage write-back,
// and saturating performance counters for lookups and mispredicts.
module branch_target_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int PERF_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  input  logic              flush,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  // Control state (reset): valid bits and direction counters.
  logic [ENTRIES-1:0]  valid_q;
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  // Data state (not reset): tags and word-aligned targets.
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  function automatic logic [CTR_BITS-1:0] ctr_sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Zero-latency lookup; outputs are meaningful whether or not lookup_en is set.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : lookup_pc + 32'd4;
  end

  // Resolution: compare the carried-down prediction against the actual outcome.
  always_comb begin
    mispredict  = upd_en && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  // Valid bits and counters: flush beats update; hits train, taken misses allocate.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_taken ? ctr_sat_inc(ctr_q[upd_idx])
                                    : ctr_sat_dec(ctr_q[upd_idx]);
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_WEAK;
      end
    end
  end

  // Tag and target payload: written on any taken update (hit retarget or allocate).
  always_ff @(posedge CLK) begin
    if (!flush && upd_en && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target[31:2];
    end
  end

  // Performance counters saturate at all-ones and clear only on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (lookup_en)  perf_lookups     <= perf_sat_inc(perf_lookups);
      if (mispredict) perf_mispredicts <= perf_sat_inc(perf_mispredicts);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with a behavioural table model
// and hand-computed literal expectations.
module tb_branch_target_predictor;

  localparam int ENT  = 16;
  localparam int CB   = 2;
  localparam int PW   = 4;
  localparam int IDXW = $clog2(ENT);
  localparam int CMAX = (1 << CB) - 1;
  localparam int WEAK = 1 << (CB - 1);
  localparam int PMAX = (1 << PW) - 1;

  logic          CLK, nRST;
  logic          lookup_en;
  logic [31:0]   lookup_pc;
  logic          pred_hit, pred_taken;
  logic [31:0]   pred_target;
  logic          upd_en, upd_taken, upd_pred_taken, flush;
  logic [31:0]   upd_pc, upd_target, upd_pred_target;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [PW-1:0] perf_lookups, perf_mispredicts;

  int n_vec = 0;
  int n_err = 0;

  // Model state.
  bit          mv   [ENT];
  int unsigned mtag [ENT];
  logic [31:0] mtgt [ENT];
  int          mctr [ENT];
  int          m_lk, m_mp;

  branch_target_predictor #(.ENTRIES(ENT), .CTR_BITS(CB), .PERF_W(PW)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int unsigned mtg(input logic [31:0] pc);
    return pc >> (2 + IDXW);
  endfunction

  function automatic bit m_mispredict();
    return upd_en && ((upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_target != upd_target));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      mv[i] = 0; mctr[i] = 0;
    end
    m_lk = 0; m_mp = 0;
  endtask

  // Compare every DUT output against what the model says it must be right now.
  task automatic check_model();
    int          i;
    bit          hit, tk;
    logic [31:0] tgt;
    i   = midx(lookup_pc);
    hit = mv[i] && (mtag[i] == mtg(lookup_pc));
    tk  = hit && (mctr[i] >= WEAK);
    tgt = tk ? mtgt[i] : lookup_pc + 32'd4;
    chk("model pred_hit", 32'(pred_hit), 32'(hit));
    chk("model pred_taken", 32'(pred_taken), 32'(tk));
    chk("model pred_target", pred_target, tgt);
    chk("model mispredict", 32'(mispredict), 32'(m_mispredict()));
    if (m_mispredict())
      chk("model redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    chk("model perf_lookups", 32'(perf_lookups), 32'((m_lk > PMAX) ? PMAX : m_lk));
    chk("model perf_mispredicts", 32'(perf_mispredicts), 32'((m_mp > PMAX) ? PMAX : m_mp));
  endtask

  // Apply the coming clock edge's effects to the model.
  task automatic model_update();
    int i;
    bit hit;
    if (lookup_en) m_lk++;
    if (m_mispredict()) m_mp++;
    if (flush) begin
      for (int k = 0; k < ENT; k++) mv[k] = 0;
    end else if (upd_en) begin
      i   = midx(upd_pc);
      hit = mv[i] && (mtag[i] == mtg(upd_pc));
      if (hit) begin
        mctr[i] = upd_taken ? ((mctr[i] < CMAX) ? mctr[i] + 1 : CMAX)
                            : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
        if (upd_taken) mtgt[i] = {upd_target[31:2], 2'b00};
      end else if (upd_taken) begin
        mv[i] = 1; mtag[i] = mtg(upd_pc); mtgt[i] = {upd_target[31:2], 2'b00}; mctr[i] = WEAK;
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    check_model();
  endtask

  task automatic fin();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_en = 1'b0; upd_taken = 1'b0; upd_pred_taken = 1'b0; flush = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; lookup_en = 1'b0; lookup_pc = 32'h100;
    upd_pc = '0; upd_target = '0; upd_pred_target = '0;
    idle();
    model_reset();
    #12 nRST = 1'b1;
    @(posedge CLK); #1;

    // Reset state.
    cyc();
    chk("reset pred_hit", 32'(pred_hit), 32'd0);
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset pred_target", pred_target, 32'h104);
    chk("reset perf_lookups", 32'(perf_lookups), 32'd0);
    chk("reset perf_mispredicts", 32'(perf_mispredicts), 32'd0);
    chk("reset mispredict", 32'(mispredict), 32'd0);
    fin();
    lookup_pc = 32'hFFFF_FFFC;
    cyc();
    chk("wrap pred_target", pred_target, 32'h0);
    fin();

    // Allocate 0x100 -> 0x80 while looking it up in the same cycle.
    lookup_pc = 32'h100;
    set_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    cyc();
    chk("alloc mispredict", 32'(mispredict), 32'd1);
    chk("alloc redirect_pc", redirect_pc, 32'h80);
    chk("same-cycle pred_hit", 32'(pred_hit), 32'd0);
    fin();
    idle();
    cyc();
    chk("after alloc pred_hit", 32'(pred_hit), 32'd1);
    chk("after alloc pred_taken", 32'(pred_taken), 32'd1);
    chk("after alloc pred_target", pred_target, 32'h80);
    fin();

    // Alias 0x140 onto index 0, then evict 0x100.
    lookup_pc = 32'h140;
    cyc();
    chk("alias pred_hit", 32'(pred_hit), 32'd0);
    chk("alias pred_target", pred_target, 32'h144);
    fin();
    set_upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    cyc(); fin();
    idle();
    cyc();
    chk("evictor pred_target", pred_target, 32'h200);
    fin();
    lookup_pc = 32'h100;
    cyc();
    chk("evicted pred_hit", 32'(pred_hit), 32'd0);
    fin();

    // Counter saturation on 0x204: alloc (2), three taken (3,3,3).
    lookup_pc = 32'h204;
    set_upd(32'h204, 1'b1, 32'h300, 1'b0, 32'h0);
    cyc(); fin();
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h204, 1'b1, 32'h300, 1'b1, 32'h300);
      cyc(); fin();
    end
    idle();
    cyc();
    chk("sat-high pred_taken", 32'(pred_taken), 32'd1);
    chk("sat-high pred_target", pred_target, 32'h300);
    fin();
    set_upd(32'h204, 1'b0, 32'h0, 1'b1, 32'h300);
    cyc();
    chk("not-taken mispredict", 32'(mispredict), 32'd1);
    chk("not-taken redirect_pc", redirect_pc, 32'h208);
    fin();
    idle();
    cyc();
    chk("ctr2 pred_taken", 32'(pred_taken), 32'd1);
    fin();
    set_upd(32'h204, 1'b0, 32'h0, 1'b1, 32'h300);
    cyc(); fin();
    idle();
    cyc();
    chk("ctr1 pred_hit", 32'(pred_hit), 32'd1);
    chk("ctr1 pred_taken", 32'(pred_taken), 32'd0);
    chk("ctr1 pred_target", pred_target, 32'h208);
    fin();
    for (int k = 0; k < 3; k++) begin
      set_upd(32'h204, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(); fin();
    end
    set_upd(32'h204, 1'b1, 32'h300, 1'b0, 32'h0);
    cyc(); fin();
    idle();
    cyc();
    chk("sat-low then taken pred_taken", 32'(pred_taken), 32'd0);
    fin();

    // Taken but wrong target is a mispredict.
    set_upd(32'h204, 1'b1, 32'h300, 1'b1, 32'h304);
    cyc();
    chk("wrong-target mispredict", 32'(mispredict), 32'd1);
    fin();

    // Flush with a same-cycle allocate: update dropped, all entries invalid.
    lookup_pc = 32'h308;
    set_upd(32'h308, 1'b1, 32'h400, 1'b0, 32'h0);
    flush = 1'b1;
    cyc(); fin();
    idle();
    cyc();
    chk("flush dropped update pred_hit", 32'(pred_hit), 32'd0);
    fin();
    lookup_pc = 32'h204;
    cyc();
    chk("flush cleared pred_hit", 32'(pred_hit), 32'd0);
    fin();

    // Perf saturation: 20 lookup cycles, each also a mispredicting taken update.
    lookup_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_upd(32'h204, 1'b1, 32'h300, 1'b0, 32'h0);
      cyc(); fin();
    end
    idle();
    lookup_en = 1'b0;
    cyc();
    chk("perf_lookups saturated", 32'(perf_lookups), 32'hF);
    chk("perf_mispredicts saturated", 32'(perf_mispredicts), 32'hF);
    fin();

    // Asynchronous reset mid-cycle.
    #1;
    chk("pre-reset pred_hit", 32'(pred_hit), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("async reset pred_hit", 32'(pred_hit), 32'd0);
    chk("async reset pred_taken", 32'(pred_taken), 32'd0);
    chk("async reset pred_target", pred_target, 32'h208);
    chk("async reset perf_lookups", 32'(perf_lookups), 32'd0);
    chk("async reset perf_mispredicts", 32'(perf_mispredicts), 32'd0);
    model_reset();
    cyc();
    #1 nRST = 1'b1;
    fin();
    cyc();
    chk("post-reset pred_hit", 32'(pred_hit), 32'd0);
    fin();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
